// File: rtl/data_bridge_fifo_if.sv
// -----------------------------------------------------------------------------
// data_bridge_fifo_if
//
// Purpose: bundles the DV/DL side signals of data_bridge_fifo so the bridge and
// its producer/consumer can be wired with a single port.
//
// Parameters:
//   WIDTH  bus width in bits (1..32)
//   DEPTH  FIFO entries (power of two, >= 2); sets the Count width
//
// Signals (direction seen from the bridge, i.e. the slave modport):
//   DataOut  in   push strobe, queues DV
//   DV       in   ALU Operand2 data to send
//   Take     in   DL consumer accepts the head entry
//   DL_out   out  DL drive value, all-ones when nothing is valid
//   DLValid  out  head entry valid on DL_out
//   Full     out  Count == DEPTH
//   Count    out  occupancy
//   Ovf      out  sticky overflow flag
//   ClrOvf   in   synchronous clear of Ovf
//   DataIn   in   capture strobe, DL -> DV direction
//   DL_in    in   sampled DL bus
//   DVCap    out  captured DL value
// -----------------------------------------------------------------------------
interface data_bridge_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             DataOut;
    logic [WIDTH-1:0] DV;
    logic             Take;
    logic [WIDTH-1:0] DL_out;
    logic             DLValid;
    logic             Full;
    logic [CW-1:0]    Count;
    logic             Ovf;
    logic             ClrOvf;
    logic             DataIn;
    logic [WIDTH-1:0] DL_in;
    logic [WIDTH-1:0] DVCap;

    // Producer/consumer side.
    modport master (
        output DataOut, DV, Take, ClrOvf, DataIn, DL_in,
        input  DL_out, DLValid, Full, Count, Ovf, DVCap
    );

    // Bridge side.
    modport slave (
        input  DataOut, DV, Take, ClrOvf, DataIn, DL_in,
        output DL_out, DLValid, Full, Count, Ovf, DVCap
    );
endinterface

// File: rtl/data_bridge_fifo.sv
// -----------------------------------------------------------------------------
// data_bridge_fifo
//
// Purpose: buffered bidirectional bridge between the ALU operand bus (DV) and
// the precharged internal databus (DL). Outgoing DV values are queued in a
// small circular FIFO and presented on DL_out with precharge semantics
// (all-ones when idle, head entry when valid). A capture register latches
// DL_in back toward the DV side.
//
// Parameters:
//   WIDTH  bus width in bits (1..32)
//   DEPTH  FIFO entries; must be a power of two and at least 2
//
// Ports:
//   CLK2    in  sole clock, rising edge
//   nRESET  in  asynchronous active-low reset
//   bus     data_bridge_fifo_if.slave (DataOut, DV, Take, DL_out, DLValid,
//           Full, Count, Ovf, ClrOvf, DataIn, DL_in, DVCap)
//
// Build option:
//   DATABRIDGE_BYPASS_EN  when defined, an empty queue forwards DV straight to
//                         DL_out while DataOut is high (legacy bridge timing);
//                         with Take also high the word is consumed directly
//                         and never queued. Undefined: DL_out is always
//                         driven from registered state, 1-cycle latency.
// -----------------------------------------------------------------------------
module data_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic                CLK2,
    input logic                nRESET,
    data_bridge_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage is deliberately not reset: an entry is only ever visible after
    // it has been written, so its power-up contents never reach DL_out.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic [WIDTH-1:0] dv_cap;

    logic empty;
    logic full;
    logic byp_hit;
    logic byp_take;
    logic push;
    logic pop;
    logic drop;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        empty = (count == '0);
        // Full comes from the registered count, so a push in the same cycle
        // as a pop from a full queue is still dropped.
        full  = (count == DEPTH_C);
`ifdef DATABRIDGE_BYPASS_EN
        byp_hit = empty && bus.DataOut;
`else
        byp_hit = 1'b0;
`endif
        // A bypassed word taken in the same cycle never enters the queue.
        byp_take = byp_hit && bus.Take;
        push     = bus.DataOut && !full && !byp_take;
        drop     = bus.DataOut && full;
        // Only real queue entries are popped; Take on an empty queue is a no-op.
        pop      = bus.Take && !empty;
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK2) begin
        if (push) begin
            mem[wr_ptr] <= bus.DV;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy (pointers wrap naturally, DEPTH is a power of 2)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK2 or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overflow: a dropped push wins over a simultaneous clear
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK2 or negedge nRESET) begin
        if (!nRESET) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (bus.ClrOvf) begin
            ovf <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // DL -> DV capture, independent of the FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK2 or negedge nRESET) begin
        if (!nRESET) begin
            dv_cap <= '1;
        end else if (bus.DataIn) begin
            dv_cap <= bus.DL_in;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs; DL_out idles at all-ones to match the precharged bus level
    // -------------------------------------------------------------------------
    always_comb begin
        if (!empty) begin
            bus.DL_out = mem[rd_ptr];
        end else if (byp_hit) begin
            bus.DL_out = bus.DV;
        end else begin
            bus.DL_out = '1;
        end
        bus.DLValid = !empty || byp_hit;
        bus.Full    = full;
        bus.Count   = count;
        bus.Ovf     = ovf;
        bus.DVCap   = dv_cap;
    end

endmodule

// File: tb/tb_data_bridge_fifo.sv
module tb_data_bridge_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef DATABRIDGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLK2;
    logic nRESET;

    data_bridge_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    data_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK2   (CLK2),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial CLK2 = 1'b0;
    always #5 CLK2 = ~CLK2;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue plus flags, updated on each rising edge.
    logic [WIDTH-1:0] mq [$];
    logic             m_ovf = 1'b0;
    logic [WIDTH-1:0] m_cap = '1;
    int               m_sz;
    bit               m_full;
    bit               m_byp_take;

    always @(posedge CLK2 or negedge nRESET) begin
        if (!nRESET) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cap = '1;
        end else begin
            m_sz       = mq.size();
            m_full     = (m_sz == DEPTH);
            m_byp_take = BYP && (m_sz == 0) && bus.DataOut && bus.Take;
            if (bus.Take && m_sz != 0) void'(mq.pop_front());
            if (bus.DataOut && !m_full && !m_byp_take) mq.push_back(bus.DV);
            if (bus.DataOut && m_full) m_ovf = 1'b1;
            else if (bus.ClrOvf) m_ovf = 1'b0;
            if (bus.DataIn) m_cap = bus.DL_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [WIDTH-1:0] e_dl;
        logic             e_valid;
        e_valid = (mq.size() != 0) || (BYP && bus.DataOut);
        if (mq.size() != 0) e_dl = mq[0];
        else if (BYP && bus.DataOut) e_dl = bus.DV;
        else e_dl = '1;
        check("model_dl_out", 32'(bus.DL_out), 32'(e_dl));
        check("model_dlvalid", 32'(bus.DLValid), 32'(e_valid));
        check("model_count", 32'(bus.Count), 32'(mq.size()));
        check("model_full", 32'(bus.Full), 32'(mq.size() == DEPTH));
        check("model_ovf", 32'(bus.Ovf), 32'(m_ovf));
        check("model_dvcap", 32'(bus.DVCap), 32'(m_cap));
    endtask

    // One clock; outputs compared on the falling edge, inputs then free to change.
    task automatic cyc();
        @(posedge CLK2);
        @(negedge CLK2);
        if (nRESET) compare_model();
    endtask

    task automatic drive(input logic d_out, input logic [WIDTH-1:0] dv, input logic take);
        bus.DataOut = d_out;
        bus.DV      = dv;
        bus.Take    = take;
    endtask

    initial begin
        nRESET     = 1'b0;
        bus.DataOut = 1'b0;
        bus.DV      = '0;
        bus.Take    = 1'b0;
        bus.ClrOvf  = 1'b0;
        bus.DataIn  = 1'b0;
        bus.DL_in   = '0;
        repeat (2) @(negedge CLK2);

        // Reset / idle
        check("rst_dl_out", 32'(bus.DL_out), 32'hFF);
        check("rst_count", 32'(bus.Count), 32'd0);
        nRESET = 1'b1;
        cyc();
        check("idle_dl_out", 32'(bus.DL_out), 32'hFF);
        check("idle_dlvalid", 32'(bus.DLValid), 32'd0);
        check("idle_count", 32'(bus.Count), 32'd0);
        check("idle_dvcap", 32'(bus.DVCap), 32'hFF);
        check("idle_full", 32'(bus.Full), 32'd0);
        check("idle_ovf", 32'(bus.Ovf), 32'd0);

        // Three pushes, then three pops
        drive(1'b1, 8'h12, 1'b0); cyc();
        check("push1_dl_out", 32'(bus.DL_out), 32'h12);
        check("push1_count", 32'(bus.Count), 32'd1);
        drive(1'b1, 8'h34, 1'b0); cyc();
        drive(1'b1, 8'h56, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0);
        check("push3_count", 32'(bus.Count), 32'd3);
        check("push3_dl_out", 32'(bus.DL_out), 32'h12);
        drive(1'b0, 8'h00, 1'b1); cyc();
        check("pop1_dl_out", 32'(bus.DL_out), 32'h34);
        check("pop1_count", 32'(bus.Count), 32'd2);
        cyc();
        check("pop2_dl_out", 32'(bus.DL_out), 32'h56);
        check("pop2_count", 32'(bus.Count), 32'd1);
        cyc();
        check("pop3_dl_out", 32'(bus.DL_out), 32'hFF);
        check("pop3_count", 32'(bus.Count), 32'd0);

        // Fill, then push while full with Take high
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0); cyc();
        end
        check("fill_full", 32'(bus.Full), 32'd1);
        check("fill_count", 32'(bus.Count), 32'd4);
        drive(1'b1, 8'hAA, 1'b1); cyc();
        check("ovf_set", 32'(bus.Ovf), 32'd1);
        check("ovf_count", 32'(bus.Count), 32'd3);
        check("ovf_dl_out", 32'(bus.DL_out), 32'h02);
        drive(1'b0, 8'h00, 1'b0);
        bus.ClrOvf = 1'b1; cyc();
        bus.ClrOvf = 1'b0;
        check("ovf_clr", 32'(bus.Ovf), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        repeat (3) cyc();
        check("drain_count", 32'(bus.Count), 32'd0);

        // Sustained push+pop at Count = 2 across pointer wrap
        drive(1'b1, 8'h10, 1'b0); cyc();
        drive(1'b1, 8'h11, 1'b0); cyc();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b1); cyc();
            check("stream_count", 32'(bus.Count), 32'd2);
        end
        check("stream_head", 32'(bus.DL_out), 32'h28);
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        check("stream_tail", 32'(bus.DL_out), 32'h29);
        cyc();
        drive(1'b0, 8'h00, 1'b0);

        // Capture path
        bus.DataIn = 1'b1; bus.DL_in = 8'h5A; cyc();
        check("cap_5a", 32'(bus.DVCap), 32'h5A);
        bus.DataIn = 1'b0; bus.DL_in = 8'h00; cyc();
        check("cap_hold", 32'(bus.DVCap), 32'h5A);

        // Empty queue, push with Take high
        drive(1'b1, 8'h3C, 1'b1);
        #1;
        if (BYP) check("byp_same_cycle", 32'(bus.DL_out), 32'h3C);
        else     check("nobyp_same_cycle", 32'(bus.DL_out), 32'hFF);
        @(negedge CLK2);
        if (nRESET) compare_model();
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        if (BYP) begin
            check("byp_count", 32'(bus.Count), 32'd0);
            check("byp_dl_out", 32'(bus.DL_out), 32'hFF);
        end else begin
            check("nobyp_count", 32'(bus.Count), 32'd1);
            check("nobyp_dl_out", 32'(bus.DL_out), 32'h3C);
        end
        @(negedge CLK2);
        drive(1'b0, 8'h00, 1'b1); cyc();
        // Take on empty queue is ignored
        cyc(); cyc();
        check("take_empty_count", 32'(bus.Count), 32'd0);
        drive(1'b0, 8'h00, 1'b0);

        // Reset mid-operation with 2 entries queued
        drive(1'b1, 8'h77, 1'b0); cyc();
        drive(1'b1, 8'h88, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0);
        check("pre_rst_count", 32'(bus.Count), 32'd2);
        #2;
        nRESET = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.Count), 32'd0);
        check("async_rst_dl_out", 32'(bus.DL_out), 32'hFF);
        check("async_rst_dlvalid", 32'(bus.DLValid), 32'd0);
        check("async_rst_dvcap", 32'(bus.DVCap), 32'hFF);
        @(negedge CLK2);
        nRESET = 1'b1;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_bridge_fifo.md
# data_bridge_fifo

Parametrised successor to the DV→DL data bridge: a buffered, bidirectional bridge between the ALU operand bus (DV) and the precharged internal databus (DL). Outgoing DV values are queued in a small FIFO and presented on DL with precharge semantics: all-ones when idle, head-of-queue data when valid. A capture register latches DL back toward the DV side. The block sits between the ALU operand path and the internal databus, and decouples producer and consumer timing on CLK2.

## Interface
- WIDTH, 8: bus width in bits, 1..32.
- DEPTH, 4: FIFO entries. Must be a power of two and at least 2.
- CLK2  in  1  sole clock; all state updates on the rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- DataOut  in  1  push strobe; queues DV.
- DV  in  WIDTH  ALU Operand2 data to send.
- Take  in  1  DL consumer accepts the head entry.
- DL_out  out  WIDTH  DL drive value; all-ones when nothing is valid (precharge).
- DLValid  out  1  head entry valid on DL_out.
- Full  out  1  Count == DEPTH.
- Count  out  $clog2(DEPTH)+1  occupancy.
- Ovf  out  1  sticky overflow flag.
- ClrOvf  in  1  synchronous clear of Ovf.
- DataIn  in  1  capture strobe, DL→DV direction.
- DL_in  in  WIDTH  sampled DL bus.
- DVCap  out  WIDTH  captured DL value.

## Operation
- The FIFO is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH, plus a Count register.
- Push: DataOut && !Full. Writes mem[wr_ptr] = DV, then wr_ptr++.
- Pop: Take && DLValid. Increments rd_ptr.
- Count update: +1 on push only, −1 on pop only, unchanged when both occur.
- DLValid = (Count != 0).
- DL_out = mem[rd_ptr] when DLValid, else {WIDTH{1'b1}}. This preserves the precharge-high idle level of DL.
- Full is decoded from the registered Count. A push while Full is dropped, even if Take is high in the same cycle. In that case the pop still occurs and Ovf is set.
- Ovf: set on any dropped push. Cleared by ClrOvf. If set and clear occur in the same cycle, set wins.
- Take while empty: ignored. No pointer or Count change, no error.
- Capture: when DataIn is high at the edge, DVCap <= DL_in. Otherwise DVCap holds. Capture is independent of FIFO state.
- Reset values: wr_ptr = rd_ptr = 0, Count = 0, Ovf = 0, DVCap = all-ones, DLValid = 0, Full = 0, DL_out = all-ones. FIFO memory contents are not reset and never become visible before a write.
- Reset mid-operation: all queued entries are discarded immediately (asynchronous). DL_out returns to all-ones in the same instant.

## Timing
- Push-to-DL latency: 1 cycle. DV sampled at edge N appears on DL_out after edge N, provided the queue was empty.
- Pop: the next entry, or all-ones, appears after the edge on which Take was accepted.
- Capture latency: 1 cycle, DL_in to DVCap.
- Full and Count are registered and change only after an edge, or on reset assertion.
- Sustained throughput: one push and one pop per cycle when 0 < Count < DEPTH.

## Configuration
- DATABRIDGE_BYPASS_EN defined: when Count == 0 and DataOut is high, DL_out = DV combinationally and DLValid = 1 in the same cycle, matching legacy bridge behaviour.
  - If Take is also high in that cycle, the value is consumed directly and not queued. Count stays 0.
  - If Take is low, the value is queued as normal.
- DATABRIDGE_BYPASS_EN undefined: no combinational path from DV to DL_out. Latency is always 1 cycle.

## Test plan
- Reset, then idle: DL_out = 8'hFF, DLValid = 0, Count = 0, DVCap = 8'hFF. Assert nRESET low with 2 entries queued: Count → 0 and DL_out → 8'hFF without waiting for a clock edge.
- Push 8'h12, 8'h34, 8'h56 on three consecutive edges, Take low, then Take high for 3 cycles: DL_out reads 8'h12, 8'h34, 8'h56, then 8'hFF; Count goes 3→2→1→0.
- Fill DEPTH=4 entries, then push 8'hAA with Take high: pop occurs, 8'hAA is dropped, Ovf = 1, Count = 3. Assert ClrOvf: Ovf = 0.
- Push and Take every cycle at Count = 2 for 10 cycles: Count stays 2 and data order is preserved across pointer wrap.
- DataIn with DL_in = 8'h5A: DVCap = 8'h5A after one edge. Then DataIn low with DL_in = 8'h00: DVCap holds 8'h5A.
- With DATABRIDGE_BYPASS_EN, empty queue, DataOut = 1, DV = 8'h3C, Take = 1: DL_out = 8'h3C in the same cycle and Count stays 0. Without the macro: DL_out = 8'hFF in that cycle and 8'h3C after the edge.
